multicycle_controller: RTL

- Sequencing FSM for the multicycle RV64I datapath: one instruction occupies several cycles and shares a single ALU and a single unified instruction/data memory port.
- Takes the opcode from the instruction register plus datapath status (branch condition, memory ready).
- Drives per-cycle mux selects, write enables and the memory request handshake.
- Adds a memory-wait watchdog, a retired-instruction counter and a sticky trap on illegal opcodes or a bus timeout.

---
 rtl/rv_ctrl_pkg.sv | 52 +++++
 rtl/mem_wait_watchdog.sv | 21 ++
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared opcodes, FSM states, datapath select encodings and trap causes
package rv_ctrl_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_AUIPC, S_LUI, S_TRAP
  } state_e;

  localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10, A_ZERO = 2'b11;
  localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_FN = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100;
  localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_BUS = 2'b10;

  // Successor of DECODE; unknown opcodes fall into TRAP
  function automatic state_e decode_next(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return S_MEMADR;
      OP_OP, OP_OP32:    return S_EXECR;
      OP_IMM, OP_IMM32:  return S_EXECI;
      OP_BRANCH:         return S_BRANCH;
      OP_JAL:            return S_JAL;
      OP_JALR:           return S_JALR;
      OP_AUIPC:          return S_AUIPC;
      OP_LUI:            return S_LUI;
      default:           return S_TRAP;
    endcase
  endfunction

  // Immediate format for the extender; unlisted opcodes default to I
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:        return IMM_S;
      OP_BRANCH:       return IMM_B;
      OP_JAL:          return IMM_J;
      OP_AUIPC, OP_LUI: return IMM_U;
      default:         return IMM_I;
    endcase
  endfunction
endpackage

// File: rtl/mem_wait_watchdog.sv
// mem_wait_watchdog: counts stalled memory cycles and flags a timeout on the last allowed one
module mem_wait_watchdog #(
  parameter int WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic waiting;
  assign waiting = active_i && !ready_i;
  assign cnt_d = waiting ? cnt_q + CW'(1) : '0;
  assign timeout_o = waiting && (cnt_q == CW'(WAIT_LIMIT - 1));
  // stall counter, cleared whenever the request completes or no request is pending
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the multicycle RV64I datapath
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_update,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [2:0]       imm_src,
  output logic             reg_write,
  output logic             is_word,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);
  state_e state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [CNT_W-1:0] instret_q;
  logic wait_active, timeout;
  assign wait_active = state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
  mem_wait_watchdog #(.WAIT_LIMIT(WAIT_LIMIT)) u_wdog (
    .clk(clk), .rst_n(rst_n), .active_i(wait_active), .ready_i(mem_ready), .timeout_o(timeout)
  );
  assign imm_src = imm_sel(opcode);
  assign is_word = opcode inside {OP_OP32, OP_IMM32};
  assign trap = state_q == S_TRAP;
  assign trap_cause = cause_q;
  assign instret = instret_q;
  // state, sticky trap cause and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_BOOT;
      cause_q <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      instret_q <= instret_q + CNT_W'(retire);
    end
  // next state and per-state datapath controls; wait states leave to TRAP on watchdog timeout
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    mem_req = 1'b0;
    mem_write = 1'b0;
    adr_src = 1'b0;
    ir_write = 1'b0;
    pc_update = 1'b0;
    reg_write = 1'b0;
    retire = 1'b0;
    alu_src_a = A_PC;
    alu_src_b = B_RS2;
    alu_op = ALU_ADD;
    result_src = RES_ALUOUT;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        alu_src_b = B_FOUR;
        result_src = RES_ALU;
        ir_write = mem_ready;
        pc_update = mem_ready;
        state_d = mem_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        state_d = decode_next(opcode);
        cause_d = (state_d == S_TRAP) ? CAUSE_ILLEGAL : cause_q;
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : timeout ? S_TRAP : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_write = 1'b1;
        adr_src = 1'b1;
        retire = mem_ready;
        state_d = mem_ready ? S_FETCH : timeout ? S_TRAP : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = A_RS1;
        alu_op = ALU_FN;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op = ALU_FN;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = A_RS1;
        alu_op = ALU_BR;
        pc_update = br_taken;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d = S_JAL;
      end
      S_JAL: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_update = 1'b1;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = A_ZERO;
        alu_src_b = B_IMM;
        state_d = S_ALUWB;
      end
      default: ;
    endcase
    if (timeout) cause_d = CAUSE_BUS;
  end
endmodule
